// File: rtl/display_7seg_contador_if.sv
// Load/busy handshake and display drive lines between the counter stage, the
// BCD display block and the board's 4-digit multiplexed 7-segment display.
interface display_7seg_contador_if #(
    parameter int N = 8
);
    logic [N-1:0] valor;
    logic         cargar;
    logic         ocupado;
    logic [3:0]   anodos;
    logic [6:0]   segmentos;
    logic         dp;

    modport master (output valor, cargar, input ocupado, anodos, segmentos, dp);
    modport slave  (input valor, cargar, output ocupado, anodos, segmentos, dp);
endinterface

// File: rtl/display_7seg_contador.sv
// Sequential binary-to-BCD (shift-add-3) feeding a 4-digit multiplexed,
// active-low 7-segment display with optional leading-zero blanking.
module display_7seg_contador #(
    parameter int N           = 8,
    parameter int REFRESH_DIV = 10000,
    parameter int BLANK_ZEROS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    display_7seg_contador_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} estado_t;

    estado_t      estado, estado_sig;
    logic [N-1:0] bin, pend_val;
    logic [15:0]  bcd, bcd_adj, disp;
    logic [3:0]   cnt;
    logic         pend;
    logic [15:0]  ref_cnt;
    logic [1:0]   idx;
    logic [3:0]   digito;
    logic         apagar;
    logic [3:0]   anodos_r;
    logic [6:0]   seg_r;

    function automatic logic [6:0] decodifica(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) estado <= IDLE;
        else      estado <= estado_sig;
    end

    // A strobe arriving in DONE is treated as already pending so it is never lost.
    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE:    if (bus.cargar) estado_sig = SHIFT;
            SHIFT:   if (cnt == 4'd1) estado_sig = DONE;
            DONE:    estado_sig = (pend || bus.cargar) ? SHIFT : IDLE;
            default: estado_sig = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++)
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            disp     <= '0;
            pend     <= 1'b0;
            pend_val <= '0;
        end else begin
            case (estado)
                IDLE: if (bus.cargar) begin
                    bin <= bus.valor;
                    bcd <= '0;
                    cnt <= 4'(N);
                end
                SHIFT: begin
                    bcd <= {bcd_adj[14:0], bin[N-1]};
                    bin <= bin << 1;
                    cnt <= cnt - 4'd1;
                    if (bus.cargar) begin
                        pend     <= 1'b1;
                        pend_val <= bus.valor;
                    end
                end
                DONE: begin
                    disp <= bcd;
                    pend <= 1'b0;
                    if (pend || bus.cargar) begin
                        bin <= bus.cargar ? bus.valor : pend_val;
                        bcd <= '0;
                        cnt <= 4'(N);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_cnt <= '0;
            idx     <= '0;
        end else if (ref_cnt == 16'(REFRESH_DIV - 1)) begin
            ref_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            ref_cnt <= ref_cnt + 16'd1;
        end
    end

    // Leading-zero test looks at this digit and everything above it; units never blank.
    always_comb begin
        digito = disp[4*idx +: 4];
        case (idx)
            2'd1:    apagar = (disp[15:4]  == 12'd0);
            2'd2:    apagar = (disp[15:8]  == 8'd0);
            2'd3:    apagar = (disp[15:12] == 4'd0);
            default: apagar = 1'b0;
        endcase
        apagar = apagar && (BLANK_ZEROS != 0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anodos_r <= 4'hF;
            seg_r    <= 7'h7F;
        end else begin
            anodos_r <= ~(4'b0001 << idx);
            seg_r    <= apagar ? 7'h7F : decodifica(digito);
        end
    end

    assign bus.anodos    = anodos_r;
    assign bus.segmentos = seg_r;
    assign bus.dp        = 1'b1;
    assign bus.ocupado   = (estado != IDLE);
endmodule

// File: tb/tb_display_7seg_contador.sv
// Directed bench: three display instances (N=8 blanked, N=8 unblanked, N=13 blanked)
// checked through their scanned anode/segment outputs.
module tb_display_7seg_contador;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    display_7seg_contador_if #(.N(8))  b0 ();
    display_7seg_contador_if #(.N(8))  b1 ();
    display_7seg_contador_if #(.N(13)) b2 ();

    display_7seg_contador #(.N(8),  .REFRESH_DIV(4), .BLANK_ZEROS(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
    display_7seg_contador #(.N(8),  .REFRESH_DIV(4), .BLANK_ZEROS(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
    display_7seg_contador #(.N(13), .REFRESH_DIV(4), .BLANK_ZEROS(1)) u2 (.clk(clk), .rst(rst), .bus(b2));

    typedef struct {
        int             inst;
        int             val;
        logic [3:0][6:0] exp;   // [0]=units .. [3]=thousands
    } vec_t;

    int         ncmp = 0;
    int         nerr = 0;
    logic [6:0] seen [3][4];
    int         falls0 = 0;
    logic       prev0 = 1'b0;

    task automatic rec(input int i, input logic [3:0] an, input logic [6:0] sg);
        case (an)
            4'b1110: seen[i][0] = sg;
            4'b1101: seen[i][1] = sg;
            4'b1011: seen[i][2] = sg;
            4'b0111: seen[i][3] = sg;
            default: ;
        endcase
    endtask

    // Latest segment pattern seen in each digit slot, plus ocupado falling edges of u0.
    always @(negedge clk) begin
        rec(0, b0.anodos, b0.segmentos);
        rec(1, b1.anodos, b1.segmentos);
        rec(2, b2.anodos, b2.segmentos);
        if (prev0 && !b0.ocupado) falls0++;
        prev0 = b0.ocupado;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic busy(input int i);
        case (i)
            0:       return b0.ocupado;
            1:       return b1.ocupado;
            default: return b2.ocupado;
        endcase
    endfunction

    task automatic drive(input int i, input int v, input logic c);
        case (i)
            0:       begin b0.valor = 8'(v);  b0.cargar = c; end
            1:       begin b1.valor = 8'(v);  b1.cargar = c; end
            default: begin b2.valor = 13'(v); b2.cargar = c; end
        endcase
    endtask

    task automatic pulse(input int i, input int v);
        drive(i, v, 1'b1);
        tick();
        drive(i, v, 1'b0);
    endtask

    task automatic check_scan(input string name, input int i, input logic [3:0][6:0] exp);
        for (int d = 0; d < 4; d++)
            check($sformatf("%s digit%0d", name, d), int'(seen[i][d]), int'(exp[d]));
    endtask

    function automatic vec_t mk(input int i, input int v, input logic [6:0] u, input logic [6:0] t,
                                input logic [6:0] h, input logic [6:0] m);
        vec_t r;
        r.inst = i;
        r.val  = v;
        r.exp  = {m, h, t, u};
        return r;
    endfunction

    initial begin
        vec_t tabla [13];
        int   n;
        int   f0;

        tabla[0]  = mk(0, 255,  7'h12, 7'h12, 7'h24, 7'h7F);
        tabla[1]  = mk(1, 7,    7'h78, 7'h40, 7'h40, 7'h40);
        tabla[2]  = mk(1, 100,  7'h40, 7'h40, 7'h79, 7'h40);
        tabla[3]  = mk(2, 8191, 7'h79, 7'h10, 7'h79, 7'h00);
        tabla[4]  = mk(0, 7,    7'h78, 7'h7F, 7'h7F, 7'h7F);
        tabla[5]  = mk(0, 100,  7'h40, 7'h40, 7'h79, 7'h7F);
        tabla[6]  = mk(0, 10,   7'h40, 7'h79, 7'h7F, 7'h7F);
        tabla[7]  = mk(0, 89,   7'h10, 7'h00, 7'h7F, 7'h7F);
        tabla[8]  = mk(0, 64,   7'h19, 7'h02, 7'h7F, 7'h7F);
        tabla[9]  = mk(2, 1000, 7'h40, 7'h40, 7'h40, 7'h79);
        tabla[10] = mk(2, 3456, 7'h02, 7'h12, 7'h19, 7'h30);
        tabla[11] = mk(2, 0,    7'h40, 7'h7F, 7'h7F, 7'h7F);
        tabla[12] = mk(1, 0,    7'h40, 7'h40, 7'h40, 7'h40);

        for (int i = 0; i < 3; i++) drive(i, 0, 1'b0);
        repeat (3) tick();

        // Reset values, then the first scan after release.
        check("rst anodos0", int'(b0.anodos), 'hF);
        check("rst seg0", int'(b0.segmentos), 'h7F);
        check("rst dp0", int'(b0.dp), 1);
        check("rst ocupado0", int'(b0.ocupado), 0);
        check("rst anodos2", int'(b2.anodos), 'hF);
        rst = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tick();
            check($sformatf("scan anodos c%0d", c), int'(b0.anodos), int'(~(4'b0001 << (c / 4)) & 4'hF));
            check($sformatf("scan seg c%0d", c), int'(b0.segmentos), (c < 4) ? 'h40 : 'h7F);
        end
        check("scan ocupado", int'(b0.ocupado), 0);

        for (int k = 0; k < 13; k++) begin
            pulse(tabla[k].inst, tabla[k].val);
            n = 0;
            while (busy(tabla[k].inst) && n < 40) begin
                n++;
                tick();
            end
            check($sformatf("v%0d busy cycles", k), n, (tabla[k].inst == 2) ? 14 : 9);
            repeat (20) tick();
            check_scan($sformatf("v%0d val %0d", k, tabla[k].val), tabla[k].inst, tabla[k].exp);
        end

        // Strobes during SHIFT coalesce: only the last value is converted afterwards.
        drive(0, 50, 1'b1); tick();
        drive(0, 60, 1'b1); tick();
        drive(0, 61, 1'b1); tick();
        drive(0, 61, 1'b0);
        n = 0;
        while (busy(0) && n < 40) begin
            n++;
            tick();
        end
        check("coalesce busy cycles", n, 16);
        repeat (20) tick();
        check_scan("coalesce 61", 0, {7'h7F, 7'h7F, 7'h02, 7'h79});

        // Back-to-back strobes 0..20.
        f0 = falls0;
        for (int v = 0; v <= 20; v++) begin
            drive(0, v, 1'b1);
            tick();
        end
        drive(0, 20, 1'b0);
        repeat (20) tick();
        check("stream drained", int'(b0.ocupado), 0);
        repeat (20) tick();
        check("stream ocupado falls", falls0 - f0, 1);
        check_scan("stream 20", 0, {7'h7F, 7'h7F, 7'h24, 7'h40});

        // Asynchronous reset in the middle of a conversion.
        pulse(0, 200);
        repeat (3) tick();
        check("pre-rst busy", int'(b0.ocupado), 1);
        rst = 1'b0;
        #2;
        check("async anodos", int'(b0.anodos), 'hF);
        check("async seg", int'(b0.segmentos), 'h7F);
        check("async ocupado", int'(b0.ocupado), 0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (20) tick();
        check("post-rst ocupado", int'(b0.ocupado), 0);
        check_scan("post-rst", 0, {7'h7F, 7'h7F, 7'h7F, 7'h40});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/display_7seg_contador.md
Name: display_7seg_contador

Overview:
- Consumes the 8-bit event count produced by the counter stage and shows it in decimal on the board's 4-digit multiplexed 7-segment display.
- Sits downstream of the counter, in the 10 MHz clock domain.
- Converts binary to BCD sequentially (shift-add-3, one bit per cycle), holds the result in a display register, and time-multiplexes the four digits.
- Anode and segment outputs are active-low and registered.

Parameters:
- N, 8, width of input value; legal range 1..13, so the result always fits in 4 BCD digits.
- REFRESH_DIV, 10000, clock cycles each digit stays lit (1 ms at 10 MHz); legal range 2..65535.
- BLANK_ZEROS, 1, 1 = leading zero digits dark (units digit always lit); 0 = all four digits shown.

Ports:
- clk  input  1  system clock (10 MHz domain).
- rst  input  1  asynchronous, active-low reset.
- valor  input  N  binary value to display; sampled only on cargar.
- cargar  input  1  single-cycle load strobe, e.g. tied to the counter enable pulse or asserted every cycle.
- ocupado  output  1  high while a conversion is in progress or pending.
- anodos  output  4  active-low one-hot digit select; bit0 = units, bit3 = thousands.
- segmentos  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active-low; always 1 (off).

Behaviour:
- Reset (rst=0, asynchronous):
  - anodos=4'hF, segmentos=7'h7F, dp=1, ocupado=0.
  - Display register=0, FSM=IDLE, digit index=0, refresh counter=0, pending flag=0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: on cargar=1, capture valor into the shift register, clear the 16-bit BCD scratch, set bit counter=N, go to SHIFT, and assert ocupado on the next cycle.
  - SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1 and decrement the bit counter. After N shift cycles go to DONE.
  - DONE: copy the BCD scratch into the display register (one cycle). If pending=1, reload from the pending value, clear pending and go to SHIFT; otherwise go to IDLE and deassert ocupado.
- Latency: the display register updates at the end of cycle N+1 after the cargar cycle (9 cycles for N=8).
- cargar while in SHIFT or DONE: the value is stored in the pending register (last write wins) and pending=1. Requests are never dropped, only coalesced.
- Arithmetic:
  - The add-3 check is applied to all 4 nibbles before each shift.
  - Inputs >9999 are impossible by the N range.
  - BCD of 255 = 0x0255.
- Multiplexer:
  - The refresh counter runs 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - On terminal count the digit index increments, wrapping 3->0.
  - anodos and segmentos are registered from (index, display register), so they lag an index change by 1 cycle.
  - Each digit is lit for exactly REFRESH_DIV cycles.
  - Mid-scan display register updates take effect at the next output register update; no glitch cleanup is required.
- Segment decode (active-low, gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Any other nibble = 7F (dark).
- Blanking (BLANK_ZEROS=1): a digit is dark (segmentos=7F) when it and every more-significant digit are 0, except the units digit. Its anode is still driven low in its slot so brightness stays uniform.
- Reset asserted mid-conversion: everything returns to reset values immediately, and the in-progress value is discarded.
- First scan after reset release: the units slot shows "0" (segmentos=40, anodos=1110).

Test Plan:
1. Reset then release, REFRESH_DIV=4, BLANK_ZEROS=1 -> anodos cycles 1110,1101,1011,0111, 4 cycles each; segmentos=40 in the units slot and 7F elsewhere; ocupado=0.
2. cargar pulse with valor=8'd255 -> ocupado high for 9 cycles. Display register = 0x0255, so the scan shows 5 (12), 5 (12), 2 (24) and thousands dark (7F).
3. valor=8'd7, then 8'd100 with BLANK_ZEROS=0 -> units 78 with 0/0/0 -> 40; then 0,0,1,0 -> 40,40,79,40.
4. cargar=1 every cycle with valor incrementing 0..20 -> no lost request; the final display register equals 0x0020 within 2*(N+2) cycles of the last strobe; ocupado falls exactly once after the stream ends.
5. rst pulsed low during SHIFT of valor=200 -> outputs return to reset values asynchronously; after release the display shows 0 and ocupado=0.
6. N=13, valor=13'd8191 -> display register = 0x8191, all four digits lit: 79 (units 1), 10 (tens 9), 79 (hundreds 1), 00 (thousands 8).
